dcache_dm: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache between the LSB and the memory IO controller (MC). Replaces the pass-through data cache. Read hits are served locally; misses and all writes go to MC. Addresses at or above `IO_BASE` bypass the cache.

---
 rtl/dcache_dm_pkg.sv | 39 +++
 rtl/dcache_dm_if.sv | 41 ++++
 rtl/dcache_extract.sv | 27 ++
 rtl/dcache_dm.sv | 195 +++++++++++++++++++
 tb/tb_dcache_dm.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_dm_pkg.sv
// Shared constants, state encoding and byte-merge helper for the direct-mapped data cache.
package dcache_dm_pkg;

    localparam int DAT_W = 32;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,
        S_WRITE = 2'd2,
        S_IO_RD = 2'd3
    } state_t;

    // Overlay low-aligned store data onto a cached word at the addressed bytes.
    function automatic logic [DAT_W-1:0] merge_bytes(
        input logic [DAT_W-1:0] word,
        input logic [DAT_W-1:0] wdat,
        input logic [1:0]       off,
        input logic [2:0]       len
    );
        logic [DAT_W-1:0] m;
        m = word;
        case (len)
            LEN_B:   m[{off, 3'b000} +: 8]        = wdat[7:0];
            LEN_H:   m[{off[1], 4'b0000} +: 16]   = wdat[15:0];
            default: m                            = wdat;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// LSB-side request/response and MC-side request/completion signals of the data cache.
interface dcache_dm_if
    import dcache_dm_pkg::*;
#(
    parameter int ADR_W = 32
);
    logic             lsb_en_i;
    logic             lsb_rwen_i;
    logic [2:0]       lsb_len_i;
    logic             lsb_sext_i;
    logic [ADR_W-1:0] lsb_adr_i;
    logic [DAT_W-1:0] lsb_dat_i;
    logic             lsb_rdy_o;
    logic             lsb_en_o;
    logic [DAT_W-1:0] lsb_dat_o;

    logic             mc_en_i;
    logic [DAT_W-1:0] mc_dat_i;
    logic             mc_en_o;
    logic             mc_rwen_o;
    logic [2:0]       mc_len_o;
    logic [ADR_W-1:0] mc_adr_o;
    logic [DAT_W-1:0] mc_dat_o;

    logic             br_flag;

    modport slave (
        input  lsb_en_i, lsb_rwen_i, lsb_len_i, lsb_sext_i, lsb_adr_i, lsb_dat_i,
        input  mc_en_i, mc_dat_i, br_flag,
        output lsb_rdy_o, lsb_en_o, lsb_dat_o,
        output mc_en_o, mc_rwen_o, mc_len_o, mc_adr_o, mc_dat_o
    );

    modport master (
        output lsb_en_i, lsb_rwen_i, lsb_len_i, lsb_sext_i, lsb_adr_i, lsb_dat_i,
        output mc_en_i, mc_dat_i, br_flag,
        input  lsb_rdy_o, lsb_en_o, lsb_dat_o,
        input  mc_en_o, mc_rwen_o, mc_len_o, mc_adr_o, mc_dat_o
    );

endinterface

// File: rtl/dcache_extract.sv
// Combinational byte/halfword select and sign/zero extension of a 32-bit word.
// Zero latency; no flow control.
module dcache_extract
    import dcache_dm_pkg::*;
(
    input  logic [DAT_W-1:0] word,
    input  logic [1:0]       off,
    input  logic [2:0]       len,
    input  logic             sext,
    output logic [DAT_W-1:0] dat
);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign sel_b = word[{off, 3'b000} +: 8];
    assign sel_h = word[{off[1], 4'b0000} +: 16];

    always_comb begin
        dat = word;
        case (len)
            LEN_B:   dat = {{(DAT_W-8){sext & sel_b[7]}}, sel_b};
            LEN_H:   dat = {{(DAT_W-16){sext & sel_h[15]}}, sel_h};
            default: dat = word;
        endcase
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache; read hit answers 1 cycle after acceptance,
// misses/IO/writes go to MC (mc_en_o +1 cycle, lsb_en_o +1 cycle after mc_en_i); lsb_rdy_o low while MC is busy.
module dcache_dm
    import dcache_dm_pkg::*;
#(
    parameter int               SETS    = 64,
    parameter int               ADR_W   = 32,
    parameter logic [ADR_W-1:0] IO_BASE = ADR_W'(IO_BASE_DEF)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    dcache_dm_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADR_W - 2 - IDX_W;

    state_t state, state_nxt;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [DAT_W-1:0] data_arr [SETS];

    logic             req_sext;
    logic [2:0]       req_len;
    logic [ADR_W-1:0] req_adr;
    logic             killed;

    logic [IDX_W-1:0] in_idx, req_idx;
    logic [TAG_W-1:0] in_tag, req_tag;
    logic             in_read, in_cacheable, in_hit;
    logic             accept, mc_done, wr_merge, rd_done_vis;
    logic             rd_hit, start_mc, fill, finish_rd, finish_wr;
    logic [DAT_W-1:0] hit_dat, fill_dat;
    logic [1:0]       fill_off;

    assign in_idx       = bus.lsb_adr_i[IDX_W+1:2];
    assign in_tag       = bus.lsb_adr_i[ADR_W-1:IDX_W+2];
    assign req_idx      = req_adr[IDX_W+1:2];
    assign req_tag      = req_adr[ADR_W-1:IDX_W+2];
    assign in_read      = (bus.lsb_rwen_i == RW_READ);
    assign in_cacheable = (bus.lsb_adr_i < IO_BASE);
    assign in_hit       = in_cacheable && valid[in_idx] && (tag_arr[in_idx] == in_tag);

    // A flushed read is dropped at the door; committed stores always proceed.
    assign accept   = en && (state == S_IDLE) && bus.lsb_en_i && !(in_read && bus.br_flag);
    assign mc_done  = en && bus.mc_en_i;
    assign wr_merge = accept && (bus.lsb_rwen_i == RW_WRITE) && in_hit;

    assign bus.lsb_rdy_o = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_hit    = 1'b0;
        start_mc  = 1'b0;
        fill      = 1'b0;
        finish_rd = 1'b0;
        finish_wr = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!in_read) begin
                        start_mc  = 1'b1;
                        state_nxt = S_WRITE;
                    end else if (in_hit) begin
                        rd_hit = 1'b1;
                    end else begin
                        start_mc  = 1'b1;
                        state_nxt = in_cacheable ? S_MISS : S_IO_RD;
                    end
                end
            end
            S_MISS: begin
                if (mc_done) begin
                    fill      = 1'b1;
                    finish_rd = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_IO_RD: begin
                if (mc_done) begin
                    finish_rd = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                if (mc_done) begin
                    finish_wr = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A flush seen at any point of an outstanding read hides its completion.
    assign rd_done_vis = finish_rd && !killed && !bus.br_flag;

    // IO data arrives low-aligned from MC; fills return the whole word.
    assign fill_off = (state == S_IO_RD) ? 2'b00 : req_adr[1:0];

    dcache_extract u_hit_ext (
        .word (data_arr[in_idx]),
        .off  (bus.lsb_adr_i[1:0]),
        .len  (bus.lsb_len_i),
        .sext (bus.lsb_sext_i),
        .dat  (hit_dat)
    );

    dcache_extract u_fill_ext (
        .word (bus.mc_dat_i),
        .off  (fill_off),
        .len  (req_len),
        .sext (req_sext),
        .dat  (fill_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.lsb_en_o  <= 1'b0;
            bus.lsb_dat_o <= '0;
            bus.mc_en_o   <= 1'b0;
            bus.mc_rwen_o <= 1'b0;
            bus.mc_len_o  <= '0;
            bus.mc_adr_o  <= '0;
            bus.mc_dat_o  <= '0;
            req_sext      <= 1'b0;
            req_len       <= '0;
            req_adr       <= '0;
            killed        <= 1'b0;
        end else if (en) begin
            bus.lsb_en_o <= rd_hit | rd_done_vis | finish_wr;
            if (rd_hit) begin
                bus.lsb_dat_o <= hit_dat;
            end else if (rd_done_vis) begin
                bus.lsb_dat_o <= fill_dat;
            end

            bus.mc_en_o <= start_mc;
            if (start_mc) begin
                bus.mc_rwen_o <= bus.lsb_rwen_i;
                bus.mc_dat_o  <= bus.lsb_dat_i;
                if (in_read && in_cacheable) begin
                    bus.mc_len_o <= LEN_W;
                    bus.mc_adr_o <= {bus.lsb_adr_i[ADR_W-1:2], 2'b00};
                end else begin
                    bus.mc_len_o <= bus.lsb_len_i;
                    bus.mc_adr_o <= bus.lsb_adr_i;
                end
            end

            if (accept) begin
                req_sext <= bus.lsb_sext_i;
                req_len  <= bus.lsb_len_i;
                req_adr  <= bus.lsb_adr_i;
            end

            if (state == S_IDLE) begin
                killed <= 1'b0;
            end else if (bus.br_flag && (state != S_WRITE)) begin
                killed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (en && fill) begin
            valid[req_idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && en) begin
            if (fill) begin
                tag_arr[req_idx]  <= req_tag;
                data_arr[req_idx] <= bus.mc_dat_i;
            end else if (wr_merge) begin
                data_arr[in_idx] <= merge_bytes(data_arr[in_idx], bus.lsb_dat_i,
                                                bus.lsb_adr_i[1:0], bus.lsb_len_i);
            end
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: vector table plus hand sequences for flush, reset and enable corners.
module tb_dcache_dm;
    import dcache_dm_pkg::*;

    logic clk;
    logic rst;
    logic en;
    int   checks;
    int   failures;

    dcache_dm_if #(.ADR_W(32)) bus ();

    dcache_dm #(
        .SETS    (64),
        .ADR_W   (32),
        .IO_BASE (32'h0003_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rwen;
        logic [2:0]  len;
        logic        sext;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        exp_mc;
        logic [2:0]  mc_len;
        logic [31:0] mc_adr;
        logic [31:0] mem_dat;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic        is_rd;
        logic [31:0] dat;
    } lsb_exp_t;

    typedef struct {
        logic        rwen;
        logic [2:0]  len;
        logic [31:0] adr;
        logic [31:0] dat;
    } mc_exp_t;

    lsb_exp_t lsb_q[$];
    mc_exp_t  mc_q[$];
    vec_t     vecs[$];

    function automatic vec_t mk(input logic rwen, input logic [2:0] len, input logic sext,
                                input logic [31:0] adr, input logic [31:0] wdat,
                                input logic exp_mc, input logic [2:0] mc_len,
                                input logic [31:0] mc_adr, input logic [31:0] mem_dat,
                                input logic [31:0] exp_dat);
        vec_t v;
        v.rwen = rwen; v.len = len; v.sext = sext; v.adr = adr; v.wdat = wdat;
        v.exp_mc = exp_mc; v.mc_len = mc_len; v.mc_adr = mc_adr;
        v.mem_dat = mem_dat; v.exp_dat = exp_dat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every LSB completion and MC request is matched against queued expectations.
    always @(negedge clk) begin
        if (bus.lsb_en_o === 1'b1) begin
            checks++;
            if (lsb_q.size() == 0) begin
                failures++;
                $display("FAIL lsb_done unexpected pulse dat=%h", bus.lsb_dat_o);
            end else begin
                lsb_exp_t e;
                e = lsb_q.pop_front();
                if (e.is_rd && bus.lsb_dat_o !== e.dat) begin
                    failures++;
                    $display("FAIL lsb_dat actual=%h required=%h", bus.lsb_dat_o, e.dat);
                end
            end
        end
        if (bus.mc_en_o === 1'b1) begin
            checks++;
            if (mc_q.size() == 0) begin
                failures++;
                $display("FAIL mc_req unexpected adr=%h", bus.mc_adr_o);
            end else begin
                mc_exp_t m;
                m = mc_q.pop_front();
                if (bus.mc_rwen_o !== m.rwen || bus.mc_len_o !== m.len || bus.mc_adr_o !== m.adr ||
                    (m.rwen == RW_WRITE && bus.mc_dat_o !== m.dat)) begin
                    failures++;
                    $display("FAIL mc_req actual rw=%b len=%0d adr=%h dat=%h required rw=%b len=%0d adr=%h dat=%h",
                             bus.mc_rwen_o, bus.mc_len_o, bus.mc_adr_o, bus.mc_dat_o,
                             m.rwen, m.len, m.adr, m.dat);
                end
            end
        end
    end

    task automatic drive_req(input logic rwen, input logic [2:0] len, input logic sext,
                             input logic [31:0] adr, input logic [31:0] wdat);
        bus.lsb_en_i   = 1'b1;
        bus.lsb_rwen_i = rwen;
        bus.lsb_len_i  = len;
        bus.lsb_sext_i = sext;
        bus.lsb_adr_i  = adr;
        bus.lsb_dat_i  = wdat;
    endtask

    task automatic mc_respond(input logic [31:0] dat);
        @(negedge clk);
        @(negedge clk);
        bus.mc_en_i  = 1'b1;
        bus.mc_dat_i = dat;
        @(negedge clk);
        bus.mc_en_i  = 1'b0;
        bus.mc_dat_i = '0;
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        drive_req(v.rwen, v.len, v.sext, v.adr, v.wdat);
        if (v.exp_mc) mc_q.push_back('{v.rwen, v.mc_len, v.mc_adr, v.wdat});
        lsb_q.push_back('{v.rwen == RW_READ, v.exp_dat});
        @(negedge clk);
        bus.lsb_en_i = 1'b0;
        if (v.exp_mc) begin
            chk("rdy_busy", {31'd0, bus.lsb_rdy_o}, 32'd0);
            seen = 0;
            for (int i = 0; i < 8 && !seen; i++) begin
                if (bus.mc_en_o === 1'b1) seen = 1;
                else @(negedge clk);
            end
            chk("mc_req_seen", {31'd0, seen}, 32'd1);
            mc_respond(v.mem_dat);
        end else begin
            chk("hit_no_mc", {31'd0, bus.mc_en_o}, 32'd0);
            chk("hit_rdy", {31'd0, bus.lsb_rdy_o}, 32'd1);
        end
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.lsb_en_o === 1'b1) seen = 1;
            else @(negedge clk);
        end
        chk("lsb_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] last_rd;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        en  = 1'b1;
        bus.lsb_en_i = 1'b0; bus.lsb_rwen_i = 1'b0; bus.lsb_len_i = '0; bus.lsb_sext_i = 1'b0;
        bus.lsb_adr_i = '0; bus.lsb_dat_i = '0; bus.mc_en_i = 1'b0; bus.mc_dat_i = '0;
        bus.br_flag = 1'b0;

        //       rw       len sx adr           wdat          mc len adr           mem           expected
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0000_0100, 32'h0,        1, 4, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk(RW_READ,  1, 1, 32'h0000_0103, 32'h0,        0, 0, 32'h0,         32'h0,         32'hFFFF_FFDE));
        vecs.push_back(mk(RW_READ,  1, 0, 32'h0000_0103, 32'h0,        0, 0, 32'h0,         32'h0,         32'h0000_00DE));
        vecs.push_back(mk(RW_READ,  2, 1, 32'h0000_0102, 32'h0,        0, 0, 32'h0,         32'h0,         32'hFFFF_DEAD));
        vecs.push_back(mk(RW_READ,  2, 0, 32'h0000_0100, 32'h0,        0, 0, 32'h0,         32'h0,         32'h0000_BEEF));
        vecs.push_back(mk(RW_WRITE, 2, 0, 32'h0000_0100, 32'h0000_1234, 1, 2, 32'h0000_0100, 32'h0,        32'h0));
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0000_0100, 32'h0,        0, 0, 32'h0,         32'h0,         32'hDEAD_1234));
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0000_0200, 32'h0,        1, 4, 32'h0000_0200, 32'hCAFE_F00D, 32'hCAFE_F00D));
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0000_0100, 32'h0,        1, 4, 32'h0000_0100, 32'hDEAD_1234, 32'hDEAD_1234));
        vecs.push_back(mk(RW_READ,  1, 0, 32'h0003_0000, 32'h0,        1, 1, 32'h0003_0000, 32'hFFFF_FFA5, 32'h0000_00A5));
        vecs.push_back(mk(RW_READ,  1, 1, 32'h0003_0000, 32'h0,        1, 1, 32'h0003_0000, 32'h0000_0081, 32'hFFFF_FF81));
        vecs.push_back(mk(RW_WRITE, 4, 0, 32'h0000_0304, 32'h5566_7788, 1, 4, 32'h0000_0304, 32'h0,        32'h0));
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0000_0304, 32'h0,        1, 4, 32'h0000_0304, 32'h5566_7788, 32'h5566_7788));
        vecs.push_back(mk(RW_READ,  1, 0, 32'h0000_0306, 32'h0,        0, 0, 32'h0,         32'h0,         32'h0000_0066));
        vecs.push_back(mk(RW_WRITE, 1, 0, 32'h0000_0305, 32'h0000_00AB, 1, 1, 32'h0000_0305, 32'h0,        32'h0));
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0000_0304, 32'h0,        0, 0, 32'h0,         32'h0,         32'h5566_AB88));
        vecs.push_back(mk(RW_READ,  2, 1, 32'h0003_0002, 32'h0,        1, 2, 32'h0003_0002, 32'h1234_8001, 32'hFFFF_8001));
        vecs.push_back(mk(RW_READ,  1, 0, 32'h0000_0507, 32'h0,        1, 4, 32'h0000_0504, 32'h9ABC_DEF0, 32'h0000_009A));
        vecs.push_back(mk(RW_READ,  4, 0, 32'h0002_FFFC, 32'h0,        1, 4, 32'h0002_FFFC, 32'h0BAD_C0DE, 32'h0BAD_C0DE));
        vecs.push_back(mk(RW_READ,  1, 1, 32'h0002_FFFF, 32'h0,        0, 0, 32'h0,         32'h0,         32'h0000_000B));
        vecs.push_back(mk(RW_READ,  1, 0, 32'h0000_0101, 32'h0,        0, 0, 32'h0,         32'h0,         32'h0000_0012));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy",     {31'd0, bus.lsb_rdy_o}, 32'd1);
        chk("reset_lsb_en",  {31'd0, bus.lsb_en_o},  32'd0);
        chk("reset_mc_en",   {31'd0, bus.mc_en_o},   32'd0);
        chk("reset_lsb_dat", bus.lsb_dat_o,          32'd0);
        chk("reset_mc_adr",  bus.mc_adr_o,           32'd0);
        chk("reset_mc_len",  {29'd0, bus.mc_len_o},  32'd0);

        last_rd = 32'd0;
        foreach (vecs[k]) begin
            run_vec(vecs[k]);
            if (vecs[k].rwen == RW_READ) last_rd = vecs[k].exp_dat;
            else chk("dat_hold_after_write", bus.lsb_dat_o, last_rd);
        end

        // Back-to-back hits on consecutive cycles.
        lsb_q.push_back('{1'b1, 32'hDEAD_1234});
        lsb_q.push_back('{1'b1, 32'hFFFF_DEAD});
        drive_req(RW_READ, 3'd4, 1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("b2b_rdy", {31'd0, bus.lsb_rdy_o}, 32'd1);
        drive_req(RW_READ, 3'd2, 1'b1, 32'h0000_0102, 32'h0);
        @(negedge clk);
        bus.lsb_en_i = 1'b0;
        chk("b2b_second_done", {31'd0, bus.lsb_en_o}, 32'd1);
        @(negedge clk);

        // Flush while a miss is outstanding: line still fills, completion is hidden.
        mc_q.push_back('{RW_READ, 3'd4, 32'h0000_0400, 32'h0});
        drive_req(RW_READ, 3'd4, 1'b0, 32'h0000_0400, 32'h0);
        @(negedge clk);
        bus.lsb_en_i = 1'b0;
        chk("flush_mc_req", {31'd0, bus.mc_en_o}, 32'd1);
        bus.br_flag = 1'b1;
        @(negedge clk);
        bus.br_flag = 1'b0;
        bus.mc_en_i  = 1'b1;
        bus.mc_dat_i = 32'h7766_5544;
        @(negedge clk);
        bus.mc_en_i  = 1'b0;
        bus.mc_dat_i = '0;
        chk("flush_no_done", {31'd0, bus.lsb_en_o}, 32'd0);
        chk("flush_rdy", {31'd0, bus.lsb_rdy_o}, 32'd1);
        @(negedge clk);
        chk("flush_no_done_late", {31'd0, bus.lsb_en_o}, 32'd0);
        run_vec(mk(RW_READ, 4, 0, 32'h0000_0400, 32'h0, 0, 0, 32'h0, 32'h0, 32'h7766_5544));

        // Flush coinciding with a read request in IDLE drops it.
        bus.br_flag = 1'b1;
        drive_req(RW_READ, 3'd4, 1'b0, 32'h0000_0800, 32'h0);
        @(negedge clk);
        bus.lsb_en_i = 1'b0;
        chk("drop_no_mc", {31'd0, bus.mc_en_o}, 32'd0);
        chk("drop_no_done", {31'd0, bus.lsb_en_o}, 32'd0);
        chk("drop_rdy", {31'd0, bus.lsb_rdy_o}, 32'd1);
        // A store under flush still goes out.
        run_vec(mk(RW_WRITE, 4, 0, 32'h0000_0900, 32'hA1B2_C3D4, 1, 4, 32'h0000_0900, 32'h0, 32'h0));
        bus.br_flag = 1'b0;
        run_vec(mk(RW_READ, 4, 0, 32'h0000_0400, 32'h0, 0, 0, 32'h0, 32'h0, 32'h7766_5544));

        // Reset mid-miss: transaction abandoned, late completion ignored, cache emptied.
        mc_q.push_back('{RW_READ, 3'd4, 32'h0000_0C00, 32'h0});
        drive_req(RW_READ, 3'd4, 1'b0, 32'h0000_0C00, 32'h0);
        @(negedge clk);
        bus.lsb_en_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rdy", {31'd0, bus.lsb_rdy_o}, 32'd1);
        chk("rst_mid_dat", bus.lsb_dat_o, 32'd0);
        bus.mc_en_i  = 1'b1;
        bus.mc_dat_i = 32'h0000_0099;
        @(negedge clk);
        bus.mc_en_i  = 1'b0;
        bus.mc_dat_i = '0;
        chk("late_mc_ignored", {31'd0, bus.lsb_en_o}, 32'd0);
        @(negedge clk);
        chk("late_mc_ignored2", {31'd0, bus.lsb_en_o}, 32'd0);
        run_vec(mk(RW_READ, 4, 0, 32'h0000_0400, 32'h0, 1, 4, 32'h0000_0400, 32'h7766_5544, 32'h7766_5544));

        // en=0 freezes the cache even with a request pending.
        en = 1'b0;
        drive_req(RW_READ, 3'd4, 1'b0, 32'h0000_0400, 32'h0);
        @(negedge clk);
        chk("freeze_no_done", {31'd0, bus.lsb_en_o}, 32'd0);
        @(negedge clk);
        chk("freeze_no_done2", {31'd0, bus.lsb_en_o}, 32'd0);
        lsb_q.push_back('{1'b1, 32'h7766_5544});
        en = 1'b1;
        @(negedge clk);
        bus.lsb_en_i = 1'b0;
        chk("unfreeze_done", {31'd0, bus.lsb_en_o}, 32'd1);
        @(negedge clk);
        @(negedge clk);

        chk("lsb_q_drained", lsb_q.size(), 32'd0);
        chk("mc_q_drained", mc_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
